// File: rtl/data_mem_arbiter.sv
// Core/external arbiter for the single-port synchronous data memory: core priority with a starvation override,
// one access in flight (IDLE -> ACCESS -> RESP), done two cycles after grant; requests are ignored while busy.
package data_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ops_t;
endpackage

module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 8,
  parameter int unsigned DATA_MEM_SIZE = 256,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [WORD_SIZE-1:0] core_addr,
  input  logic [WORD_SIZE-1:0] core_wdata,
  output logic                 core_gnt,
  output logic                 core_done,
  output logic                 core_err,
  output logic [WORD_SIZE-1:0] core_rdata,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [WORD_SIZE-1:0] ext_addr,
  input  logic [WORD_SIZE-1:0] ext_wdata,
  output logic                 ext_gnt,
  output logic                 ext_done,
  output logic                 ext_err,
  output logic [WORD_SIZE-1:0] ext_rdata,
  output logic [WORD_SIZE-1:0] mem_addr,
  output mem_ops_t             mem_op,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        starve_cnt, starve_cnt_nxt;
  logic                 owner_ext, owner_ext_nxt;
  logic                 is_read, is_read_nxt;
  logic                 err_pending, err_pending_nxt;
  logic                 core_gnt_nxt, core_done_nxt, core_err_nxt;
  logic                 ext_gnt_nxt, ext_done_nxt, ext_err_nxt;
  logic [WORD_SIZE-1:0] core_rdata_nxt, ext_rdata_nxt;
  logic [WORD_SIZE-1:0] mem_addr_nxt, mem_wdata_nxt;
  mem_ops_t             mem_op_nxt;
  logic                 busy_nxt;

  logic                 core_win, ext_win, sel_we, in_range;
  logic [WORD_SIZE-1:0] sel_addr, sel_wdata;

  always_comb begin
    // core keeps priority unless ext has waited through STARVE_LIMIT core wins
    core_win  = core_req && !(ext_req && (starve_cnt == LIMIT));
    ext_win   = ext_req && !core_win;
    sel_we    = ext_win ? ext_we    : core_we;
    sel_addr  = ext_win ? ext_addr  : core_addr;
    sel_wdata = ext_win ? ext_wdata : core_wdata;
    in_range  = 32'(sel_addr) < DATA_MEM_SIZE;

    state_nxt       = state;
    starve_cnt_nxt  = starve_cnt;
    owner_ext_nxt   = owner_ext;
    is_read_nxt     = is_read;
    err_pending_nxt = err_pending;
    core_gnt_nxt    = 1'b0;
    core_done_nxt   = 1'b0;
    core_err_nxt    = 1'b0;
    ext_gnt_nxt     = 1'b0;
    ext_done_nxt    = 1'b0;
    ext_err_nxt     = 1'b0;
    core_rdata_nxt  = core_rdata;
    ext_rdata_nxt   = ext_rdata;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    mem_op_nxt      = MEM_NOP;

    case (state)
      IDLE: begin
        if (core_win || ext_win) begin
          core_gnt_nxt    = core_win;
          ext_gnt_nxt     = ext_win;
          mem_addr_nxt    = sel_addr;
          mem_wdata_nxt   = sel_wdata;
          mem_op_nxt      = !in_range ? MEM_NOP : (sel_we ? MEM_WRITE : MEM_READ);
          owner_ext_nxt   = ext_win;
          is_read_nxt     = !sel_we;
          err_pending_nxt = !in_range;
          if (ext_win)
            starve_cnt_nxt = '0;
          else if (ext_req && (starve_cnt != LIMIT))
            starve_cnt_nxt = starve_cnt + 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        if (owner_ext) begin
          ext_done_nxt = 1'b1;
          ext_err_nxt  = err_pending;
          if (is_read) ext_rdata_nxt = err_pending ? '0 : mem_rdata;
        end else begin
          core_done_nxt = 1'b1;
          core_err_nxt  = err_pending;
          if (is_read) core_rdata_nxt = err_pending ? '0 : mem_rdata;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      owner_ext   <= 1'b0;
      is_read     <= 1'b0;
      err_pending <= 1'b0;
      core_gnt    <= 1'b0;
      core_done   <= 1'b0;
      core_err    <= 1'b0;
      core_rdata  <= '0;
      ext_gnt     <= 1'b0;
      ext_done    <= 1'b0;
      ext_err     <= 1'b0;
      ext_rdata   <= '0;
      mem_addr    <= '0;
      mem_op      <= MEM_NOP;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_cnt_nxt;
      owner_ext   <= owner_ext_nxt;
      is_read     <= is_read_nxt;
      err_pending <= err_pending_nxt;
      core_gnt    <= core_gnt_nxt;
      core_done   <= core_done_nxt;
      core_err    <= core_err_nxt;
      core_rdata  <= core_rdata_nxt;
      ext_gnt     <= ext_gnt_nxt;
      ext_done    <= ext_done_nxt;
      ext_err     <= ext_err_nxt;
      ext_rdata   <= ext_rdata_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_op      <= mem_op_nxt;
      mem_wdata   <= mem_wdata_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-level model with a reference memory.
// A second instance with STARVE_LIMIT=0 covers the ext-always-wins corner.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int MSIZE = 128;
  localparam int LIM   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       core_req, core_we, ext_req, ext_we;
  logic [7:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic       core_gnt, core_done, core_err, ext_gnt, ext_done, ext_err, busy;
  logic [7:0] core_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  mem_ops_t   mem_op;

  data_mem_arbiter #(.WORD_SIZE(8), .DATA_MEM_SIZE(MSIZE), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_err(ext_err), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_op(mem_op), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  logic       z_reset, z_core_req, z_ext_req;
  logic       z_core_gnt, z_core_done, z_core_err, z_ext_gnt, z_ext_done, z_ext_err, z_busy;
  logic [7:0] z_core_rdata, z_ext_rdata, z_mem_addr, z_mem_wdata;
  mem_ops_t   z_mem_op;

  data_mem_arbiter #(.WORD_SIZE(8), .DATA_MEM_SIZE(256), .STARVE_LIMIT(0)) u_lim0 (
    .clk(clk), .reset(z_reset),
    .core_req(z_core_req), .core_we(1'b0), .core_addr(8'h05), .core_wdata(8'h00),
    .core_gnt(z_core_gnt), .core_done(z_core_done), .core_err(z_core_err), .core_rdata(z_core_rdata),
    .ext_req(z_ext_req), .ext_we(1'b0), .ext_addr(8'h06), .ext_wdata(8'h00),
    .ext_gnt(z_ext_gnt), .ext_done(z_ext_done), .ext_err(z_ext_err), .ext_rdata(z_ext_rdata),
    .mem_addr(z_mem_addr), .mem_op(z_mem_op), .mem_wdata(z_mem_wdata), .mem_rdata(8'h5A),
    .busy(z_busy)
  );

  // synchronous memory; read data is junk unless a read was sampled
  logic       preload_en;
  logic [7:0] mem_arr [256];

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : 8'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
    end else if (mem_op == MEM_WRITE) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    if (mem_op == MEM_READ) mem_rdata <= mem_arr[mem_addr];
    else mem_rdata <= 8'($urandom);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // transaction-level reference state
  logic [7:0] mem_ref [256];
  int         k = 0;
  int         last_g = -100;
  int         streak = 0;
  logic [7:0] exp_crd = 8'h00;
  logic [7:0] exp_erd = 8'h00;
  bit         p_ext, p_read, p_err;
  logic [7:0] p_data;

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(2) == 0) return 8'($urandom);
    return 8'(8'h10 + $urandom_range(7));
  endfunction

  task automatic new_core(input int pct);
    core_req   = ($urandom_range(99) < pct);
    core_we    = 1'($urandom_range(1));
    core_addr  = rand_addr();
    core_wdata = 8'($urandom);
  endtask

  task automatic new_ext(input int pct);
    ext_req   = ($urandom_range(99) < pct);
    ext_we    = 1'($urandom_range(1));
    ext_addr  = rand_addr();
    ext_wdata = 8'($urandom);
  endtask

  // one clock: predict the winner for the coming edge, advance, compare, update requesters
  task automatic step(input int pct);
    bit         wc, wx, wr, in_rng, dn;
    logic [7:0] a, d;
    mem_ops_t   eop;
    wc = 1'b0;
    wx = 1'b0;
    if (!reset && (k + 1 - last_g >= 3)) begin
      if (core_req && ext_req) begin
        if (streak == LIM) wx = 1'b1;
        else wc = 1'b1;
      end else if (core_req) wc = 1'b1;
      else if (ext_req) wx = 1'b1;
    end
    a  = wx ? ext_addr  : core_addr;
    d  = wx ? ext_wdata : core_wdata;
    wr = wx ? ext_we    : core_we;

    @(negedge clk);
    k++;
    if (reset) begin
      last_g  = -100;
      streak  = 0;
      exp_crd = 8'h00;
      exp_erd = 8'h00;
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
    end
    check("core_gnt", 32'(core_gnt), 32'(wc));
    check("ext_gnt", 32'(ext_gnt), 32'(wx));
    if (wc || wx) begin
      in_rng = (a < MSIZE);
      eop    = !in_rng ? MEM_NOP : (wr ? MEM_WRITE : MEM_READ);
      check("mem_addr", 32'(mem_addr), 32'(a));
      check("mem_wdata", 32'(mem_wdata), 32'(d));
      check("mem_op_grant", 32'(mem_op), 32'(eop));
      last_g = k;
      p_ext  = wx;
      p_read = !wr;
      p_err  = !in_rng;
      p_data = in_rng ? mem_ref[a] : 8'h00;
      if (in_rng && wr) mem_ref[a] = d;
      if (wx) streak = 0;
      else if (ext_req && streak < LIM) streak++;
    end else begin
      check("mem_op_nop", 32'(mem_op), 32'(MEM_NOP));
    end

    dn = (k - last_g == 2);
    if (dn && p_read) begin
      if (p_ext) exp_erd = p_data;
      else exp_crd = p_data;
    end
    check("core_done", 32'(core_done), 32'(dn && !p_ext));
    check("ext_done", 32'(ext_done), 32'(dn && p_ext));
    check("core_err", 32'(core_err), 32'(dn && !p_ext && p_err));
    check("ext_err", 32'(ext_err), 32'(dn && p_ext && p_err));
    check("core_rdata", 32'(core_rdata), 32'(exp_crd));
    check("ext_rdata", 32'(ext_rdata), 32'(exp_erd));
    check("busy", 32'(busy), 32'((k - last_g) < 2));

    if (reset) begin
      core_req = 1'b0;
      ext_req  = 1'b0;
    end else begin
      if (wc || !core_req) new_core(pct);
      if (wx || !ext_req) new_ext(pct);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int zc, zx;
    bit got;
    reset = 1'b1; preload_en = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;
    z_reset = 1'b1; z_core_req = 1'b0; z_ext_req = 1'b0;
    for (int i = 0; i < 256; i++) mem_ref[i] = init_val(i);
    @(negedge clk);
    preload_en = 1'b0;

    // STARVE_LIMIT=0: ext wins every arbitration while it requests
    z_reset = 1'b0; z_core_req = 1'b1; z_ext_req = 1'b1;
    zc = 0; zx = 0;
    repeat (12) begin
      @(negedge clk);
      zc += int'(z_core_gnt);
      zx += int'(z_ext_gnt);
    end
    check("lim0_ext_gnts", 32'(zx), 4);
    check("lim0_core_gnts", 32'(zc), 0);
    check("lim0_ext_rdata", 32'(z_ext_rdata), 32'h5A);
    z_ext_req = 1'b0;
    zc = 0;
    repeat (6) begin
      @(negedge clk);
      zc += int'(z_core_gnt);
    end
    check("lim0_core_alone", 32'(zc), 2);
    check("lim0_core_rdata", 32'(z_core_rdata), 32'h5A);

    step(0);
    reset = 1'b0;

    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    repeat (3) step(0);
    check("dir_core_read", 32'(core_rdata), 32'hA5);

    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h20; ext_wdata = 8'h3C;
    repeat (3) step(0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
    repeat (3) step(0);
    check("dir_raw_read", 32'(core_rdata), 32'h3C);

    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'hF0;
    repeat (3) step(0);
    check("dir_oor_rdata", 32'(ext_rdata), 32'h00);

    repeat (400) step(40);
    repeat (200) step(100);
    repeat (300) step(70);

    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step(100);
      if (last_g == k) got = 1'b1;
    end
    check("rst_wait_grant", 32'(got), 1);
    reset = 1'b1;
    step(0);
    reset = 1'b0;

    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    repeat (3) step(0);
    check("post_rst_read", 32'(core_rdata), 32'(mem_ref[16]));

    repeat (150) step(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port synchronous data memory between two requesters.
- Core side: control_unit load/store/push/pop traffic.
- External side: program/data loader or debug port.
- Fixed core priority, with a starvation counter that forces an external grant after STARVE_LIMIT consecutive core wins.
- Sits between the requesters and the data memory. Drives the memory's addr/op/wdata and returns read data plus a completion pulse to the owner.

Parameters:
WORD_SIZE, 8, data and address width (matches instruction_set package)
DATA_MEM_SIZE, 256, number of valid memory locations; addresses >= this are out of range
STARVE_LIMIT, 4, consecutive core grants while ext_req is pending before ext is forced; 0 = ext always wins when requesting

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
core_req  in  1  core access request (level, held until core_gnt)
core_we  in  1  1 = write, 0 = read
core_addr  in  WORD_SIZE  core address
core_wdata  in  WORD_SIZE  core write data
core_gnt  out  1  one-cycle pulse: core request accepted
core_done  out  1  one-cycle pulse: core access complete
core_err  out  1  one-cycle pulse with core_done: address out of range
core_rdata  out  WORD_SIZE  read data, valid while core_done=1 and read
ext_req, ext_we, ext_addr, ext_wdata  in  1/1/WORD_SIZE/WORD_SIZE  external request, same rules as core
ext_gnt, ext_done, ext_err  out  1  external equivalents of core_gnt/core_done/core_err
ext_rdata  out  WORD_SIZE  external read data
mem_addr  out  WORD_SIZE  memory address
mem_op  out  MEM_OPS_T  MEM_NOP / MEM_READ / MEM_WRITE
mem_wdata  out  WORD_SIZE  memory write data
mem_rdata  in  WORD_SIZE  memory read data, valid the cycle after the memory samples MEM_READ
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - State IDLE; starve_cnt 0.
  - All gnt/done/err outputs 0; rdata registers 0.
  - mem_addr 0; mem_op MEM_NOP; mem_wdata 0; busy 0.
- All outputs are registered.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Exactly one access in flight; one access per 3 cycles max.
- IDLE, edge E0, arbitration:
  - Neither req: stay IDLE.
  - Only core_req: core wins.
  - Only ext_req: ext wins.
  - Both, starve_cnt < STARVE_LIMIT: core wins.
  - Both, starve_cnt == STARVE_LIMIT: ext wins.
- IDLE, edge E0, on a win:
  - Winner's gnt = 1.
  - mem_addr and mem_wdata register the winner's addr/wdata; mem_op = MEM_WRITE if we, else MEM_READ.
  - Owner is latched; state -> ACCESS.
- Out-of-range address (addr >= DATA_MEM_SIZE): still granted, but mem_op stays MEM_NOP and err_pending is latched.
- starve_cnt:
  - +1 when core wins while ext_req = 1 (saturates at STARVE_LIMIT).
  - Cleared to 0 when ext wins.
  - Held otherwise.
- ACCESS, edge E1: gnt -> 0; mem_op -> MEM_NOP (memory has sampled at E1); mem_addr holds; state -> RESP.
- RESP, edge E2:
  - Owner's done = 1 for one cycle.
  - Reads: owner's rdata <- mem_rdata, or 0 if err_pending.
  - Writes: rdata holds its previous value.
  - Owner's err = err_pending. State -> IDLE.
  - Non-owner's outputs are untouched.
- rdata is sticky until that requester's next read completes.
- Requests are ignored in ACCESS/RESP; there is no queueing.
- A req still high at the first IDLE edge after gnt is a new request.
- Requesters must hold addr/we/wdata stable from req assertion until gnt.
- Done latency: 2 cycles after gnt. An earliest new grant is at edge E3.
- Reset asserted in any state returns everything to reset values on that edge. An in-flight access produces no done/err pulse; a write already presented at E1 may have completed in memory.

Test Plan:
- Core read only: mem preloaded [0x10]=0xA5; core_req, we=0, addr=0x10 -> core_gnt at cycle+1, mem_op=MEM_READ exactly one cycle, core_done with core_rdata=0xA5 two cycles after gnt; ext outputs stay 0.
- Ext write then core read: ext write 0x3C to 0x20, then core reads 0x20 -> mem_op=MEM_WRITE addr 0x20 data 0x3C; core_rdata=0x3C; grants 3 cycles apart.
- Starvation, STARVE_LIMIT=4: core_req and ext_req held high continuously -> grant sequence core,core,core,core,ext,core,... ; starve_cnt returns to 0 after the ext grant.
- STARVE_LIMIT=0: both requesting -> ext granted every time while ext_req is high.
- Out of range, DATA_MEM_SIZE=128: ext read addr 0xF0 -> ext_gnt, mem_op stays MEM_NOP, ext_done and ext_err together, ext_rdata=0x00.
- Reset mid-operation: reset high in ACCESS -> next cycle busy=0, mem_op=MEM_NOP, no done pulse; a subsequent core read at 0x10 completes normally.
